// File: rtl/bsg_comm_link_credit_tx_pkg.sv
// Shared defaults and helpers for the credit-gated link transmitter.
// No logic of its own.
package bsg_comm_link_credit_tx_pkg;

    localparam int unsigned DEFAULT_WIDTH          = 8;
    localparam int unsigned DEFAULT_LG_FIFO_DEPTH  = 5;
    localparam int unsigned DEFAULT_LG_DECIMATION  = 3;

    function automatic int unsigned pow2(input int unsigned lg);
        return 32'd1 << lg;
    endfunction

endpackage

// File: rtl/bsg_comm_link_credit_tx_counter.sv
// Saturating credit counter: +2^lg_up_p per up, -1 per down, result visible next cycle.
// Never stalls; an over-range sum clamps to 2^lg_max_p and raises a sticky overflow flag.
module bsg_comm_link_credit_tx_counter
    import bsg_comm_link_credit_tx_pkg::*;
#(
    parameter int unsigned lg_max_p = DEFAULT_LG_FIFO_DEPTH,
    parameter int unsigned lg_up_p  = DEFAULT_LG_DECIMATION
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              up_i,
    input  logic              down_i,
    output logic [lg_max_p:0] count_o,
    output logic              overflow_o
);

    localparam int unsigned CW = lg_max_p + 1;
    localparam int unsigned NW = lg_max_p + 2;
    localparam logic [NW-1:0] MAX_N  = NW'(pow2(lg_max_p));
    localparam logic [NW-1:0] STEP_N = NW'(pow2(lg_up_p));

    logic [CW-1:0] count_r;
    logic          overflow_r;
    logic [NW-1:0] count_n;

    // One extra bit of headroom so up+down can never wrap before the clamp.
    always_comb begin
        count_n = {1'b0, count_r} + (up_i ? STEP_N : '0) - NW'(down_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r    <= MAX_N[CW-1:0];
            overflow_r <= 1'b0;
        end else if (count_n > MAX_N) begin
            count_r    <= MAX_N[CW-1:0];
            overflow_r <= 1'b1;
        end else begin
            count_r    <= count_n[CW-1:0];
        end
    end

    assign count_o    = count_r;
    assign overflow_o = overflow_r;

endmodule

// File: rtl/bsg_comm_link_credit_tx.sv
// Credit-gated one-entry output stage; accepted word on v_o/data_o next cycle, token credit next cycle.
// ready_o drops when credits are zero or the held word is not being consumed (yumi_i=0).
module bsg_comm_link_credit_tx
    import bsg_comm_link_credit_tx_pkg::*;
#(
    parameter int unsigned width_p                         = DEFAULT_WIDTH,
    parameter int unsigned lg_fifo_depth_p                 = DEFAULT_LG_FIFO_DEPTH,
    parameter int unsigned lg_credit_to_token_decimation_p = DEFAULT_LG_DECIMATION
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     token_toggle_i,
    input  logic                     v_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i,
    output logic [lg_fifo_depth_p:0] credits_o,
    output logic                     overflow_o
);

    logic               token_r;
    logic               token_edge;
    logic               accept;
    logic               v_r;
    logic [width_p-1:0] data_r;

    // Loading the live level during reset as well keeps the first cycle edge-free.
    always_ff @(posedge clk_i) begin
        token_r <= token_toggle_i;
    end

    assign token_edge = token_r ^ token_toggle_i;
    assign ready_o    = (credits_o != '0) & (~v_r | yumi_i);
    assign accept     = v_i & ready_o;

    bsg_comm_link_credit_tx_counter #(
        .lg_max_p (lg_fifo_depth_p),
        .lg_up_p  (lg_credit_to_token_decimation_p)
    ) credit_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .up_i       (token_edge),
        .down_i     (accept),
        .count_o    (credits_o),
        .overflow_o (overflow_o)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_r    <= 1'b0;
            data_r <= '0;
        end else if (accept) begin
            v_r    <= 1'b1;
            data_r <= data_i;
        end else if (yumi_i) begin
            v_r    <= 1'b0;
        end
    end

    assign v_o    = v_r;
    assign data_o = data_r;

endmodule

// File: tb/tb_bsg_comm_link_credit_tx.sv
// Directed bench for the credit-gated transmitter (width 8, 32 credits, 8 credits per token).
module tb_bsg_comm_link_credit_tx;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       token_toggle_i;
    logic       v_i;
    logic [7:0] data_i;
    logic       ready_o;
    logic       v_o;
    logic [7:0] data_o;
    logic       yumi_i;
    logic [5:0] credits_o;
    logic       overflow_o;

    int n_cmp = 0;
    int n_bad = 0;

    bsg_comm_link_credit_tx #(
        .width_p                         (8),
        .lg_fifo_depth_p                 (5),
        .lg_credit_to_token_decimation_p (3)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .token_toggle_i (token_toggle_i),
        .v_i            (v_i),
        .data_i         (data_i),
        .ready_o        (ready_o),
        .v_o            (v_o),
        .data_o         (data_o),
        .yumi_i         (yumi_i),
        .credits_o      (credits_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are read 1ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        data_i  = 8'h00;
        tick();
        tick();
        reset_i = 1'b0;
        #1;
    endtask

    // Stream with yumi tied to v_o for n cycles; returns number of accepts.
    task automatic stream(input int n, output int acc, output int first_stall);
        acc = 0;
        first_stall = -1;
        for (int c = 0; c < n; c++) begin
            tick();
            v_i    = 1'b1;
            data_i = 8'(c);
            yumi_i = v_o;
            #1;
            if (ready_o) acc++;
            else if (first_stall < 0) first_stall = c;
        end
    endtask

    initial begin
        int acc;
        int stall;

        token_toggle_i = 1'b0;
        do_reset();
        check("rst_credits", credits_o, 32);
        check("rst_ready", ready_o, 1);
        check("rst_v", v_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_data", data_o, 0);

        // Drain all 32 credits back-to-back.
        acc = 0;
        stall = -1;
        for (int c = 0; c < 40; c++) begin
            v_i    = 1'b1;
            data_i = 8'(c);
            yumi_i = v_o;
            #1;
            if (ready_o) acc++;
            else if (stall < 0) stall = c;
            if (c == 32) check("last_word", data_o, 31);
            tick();
        end
        check("drain_accepts", acc, 32);
        check("drain_stall_cycle", stall, 32);
        check("drain_credits", credits_o, 0);

        // One token returns 8 credits.
        v_i = 1'b0;
        yumi_i = v_o;
        token_toggle_i = ~token_toggle_i;
        #1;
        check("tok_ready_before", ready_o, 0);
        tick();
        yumi_i = 1'b0;
        #1;
        check("tok_credits", credits_o, 8);
        check("tok_ready_after", ready_o, 1);
        stream(20, acc, stall);
        check("tok_accepts", acc, 8);
        check("tok_credits_end", credits_o, 0);

        // Simultaneous accept and token at 4 credits gives 11.
        tick();
        v_i = 1'b0;
        yumi_i = v_o;
        token_toggle_i = ~token_toggle_i;
        tick();
        yumi_i = 1'b0;
        #1;
        check("refill_credits", credits_o, 8);
        stream(4, acc, stall);
        tick();
        v_i = 1'b0;
        yumi_i = v_o;
        #1;
        check("pre_simul_credits", credits_o, 4);
        v_i = 1'b1;
        data_i = 8'h77;
        token_toggle_i = ~token_toggle_i;
        #1;
        check("simul_ready", ready_o, 1);
        tick();
        v_i = 1'b0;
        yumi_i = 1'b0;
        #1;
        check("simul_credits", credits_o, 11);
        check("simul_data", data_o, 8'h77);

        // Token at full credits saturates and sets sticky overflow.
        do_reset();
        token_toggle_i = ~token_toggle_i;
        tick();
        check("ovf_credits", credits_o, 32);
        check("ovf_flag", overflow_o, 1);
        stream(3, acc, stall);
        tick();
        v_i = 1'b0;
        yumi_i = 1'b0;
        #1;
        check("ovf_sticky", overflow_o, 1);
        check("ovf_traffic_credits", credits_o, 29);
        check("ovf_held_v", v_o, 1);
        do_reset();
        check("ovf_clear", overflow_o, 0);
        check("midrst_credits", credits_o, 32);
        check("midrst_v", v_o, 0);

        // Backpressure: held word stays put, one credit spent.
        v_i = 1'b1;
        data_i = 8'hA5;
        yumi_i = 1'b0;
        tick();
        data_i = 8'h3C;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_v", v_o, 1);
            check("bp_data", data_o, 8'hA5);
            check("bp_ready", ready_o, 0);
            tick();
        end
        check("bp_credits", credits_o, 31);
        data_i = 8'h5A;
        yumi_i = 1'b1;
        #1;
        check("pass_ready", ready_o, 1);
        tick();
        v_i = 1'b0;
        #1;
        check("pass_v", v_o, 1);
        check("pass_data", data_o, 8'h5A);
        check("pass_credits", credits_o, 30);
        tick();
        yumi_i = 1'b0;
        #1;
        check("drain_v", v_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
